// File: rtl/pcc_stream_acc.sv
// -----------------------------------------------------------------------------
// pcc_stream_acc
//
// Streaming popcount comparator. Accepts frames of one or more beats, each
// carrying a positive and a negative feature vector. Running popcounts of both
// vectors (and a beat count) are accumulated with saturation. When the last
// beat of a frame is accepted, the final counts and the decision
// "pos >= neg" are latched into registered outputs and held until the
// consumer takes them.
//
// Optional build macro: PCC_THRESH_EN
//   When defined, a signed threshold input is added and the decision becomes
//   (pos - neg) >= thresh, evaluated signed in CNT_W+2 bits.
//
// Ports:
//   clk          clock, all state updates on rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     beat offered
//   in_ready     block can accept a beat (high only while accumulating)
//   in_pos       positive bits of this beat          [POS_W]
//   in_neg       negative bits of this beat          [NEG_W]
//   in_last      beat is the final beat of its frame
//   out_valid    frame result available
//   out_ready    consumer takes the result
//   out_ge       decision for the frame
//   out_pos_cnt  final saturated positive count      [CNT_W]
//   out_neg_cnt  final saturated negative count      [CNT_W]
//   out_beats    beats in frame, saturated           [CNT_W]
//   out_sat      some counter clamped during the frame
//   thresh       signed threshold [CNT_W+1] (PCC_THRESH_EN only)
// -----------------------------------------------------------------------------
module pcc_stream_acc #(
   parameter int POS_W = 2,
   parameter int NEG_W = 6,
   parameter int CNT_W = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [POS_W-1:0]        in_pos,
   input  logic [NEG_W-1:0]        in_neg,
   input  logic                    in_last,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    out_ge,
   output logic [CNT_W-1:0]        out_pos_cnt,
   output logic [CNT_W-1:0]        out_neg_cnt,
   output logic [CNT_W-1:0]        out_beats,
   output logic                    out_sat
`ifdef PCC_THRESH_EN
   ,
   input  logic signed [CNT_W:0]   thresh
`endif
);

   typedef enum logic {
      ST_ACC  = 1'b0,
      ST_DONE = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   acc_p_q, acc_p_d;
   logic [CNT_W-1:0]   acc_n_q, acc_n_d;
   logic [CNT_W-1:0]   beats_q, beats_d;
   logic               sat_q, sat_d;
   logic               out_valid_q, out_valid_d;
   logic               out_ge_q, out_ge_d;
   logic [CNT_W-1:0]   out_pos_q, out_pos_d;
   logic [CNT_W-1:0]   out_neg_q, out_neg_d;
   logic [CNT_W-1:0]   out_beats_q, out_beats_d;
   logic               out_sat_q, out_sat_d;

   logic               accept;
   logic [CNT_W-1:0]   pc_p, pc_n;
   logic [CNT_W:0]     sum_p, sum_n, sum_b;
   logic [CNT_W-1:0]   nxt_p, nxt_n, nxt_b;
   logic               nxt_sat;
   logic               decision;

   assign in_ready = (state_q == ST_ACC);
   assign accept   = in_valid && in_ready;

   // Popcounts of the current beat; CNT_W is wide enough for either vector.
   always_comb begin
      pc_p = '0;
      for (int i = 0; i < POS_W; i++) begin
         pc_p = pc_p + CNT_W'(in_pos[i]);
      end
      pc_n = '0;
      for (int i = 0; i < NEG_W; i++) begin
         pc_n = pc_n + CNT_W'(in_neg[i]);
      end
   end

   // Sums carry one extra bit; a set carry means the result must clamp.
   always_comb begin
      sum_p   = {1'b0, acc_p_q} + {1'b0, pc_p};
      sum_n   = {1'b0, acc_n_q} + {1'b0, pc_n};
      sum_b   = {1'b0, beats_q} + (CNT_W+1)'(1);
      nxt_p   = sum_p[CNT_W] ? '1 : sum_p[CNT_W-1:0];
      nxt_n   = sum_n[CNT_W] ? '1 : sum_n[CNT_W-1:0];
      nxt_b   = sum_b[CNT_W] ? '1 : sum_b[CNT_W-1:0];
      nxt_sat = sat_q | sum_p[CNT_W] | sum_n[CNT_W] | sum_b[CNT_W];
   end

`ifdef PCC_THRESH_EN
   // Two extra bits hold the full range of an unsigned difference, and the
   // threshold is sign-extended to the same width before comparing.
   logic signed [CNT_W+1:0] diff;
   logic signed [CNT_W+1:0] thresh_ext;
   always_comb begin
      diff       = $signed({2'b00, nxt_p}) - $signed({2'b00, nxt_n});
      thresh_ext = $signed({thresh[CNT_W], thresh});
      decision   = (diff >= thresh_ext);
   end
`else
   always_comb begin
      decision = (nxt_p >= nxt_n);
   end
`endif

   always_comb begin
      state_d     = state_q;
      acc_p_d     = acc_p_q;
      acc_n_d     = acc_n_q;
      beats_d     = beats_q;
      sat_d       = sat_q;
      out_valid_d = out_valid_q;
      out_ge_d    = out_ge_q;
      out_pos_d   = out_pos_q;
      out_neg_d   = out_neg_q;
      out_beats_d = out_beats_q;
      out_sat_d   = out_sat_q;
      case (state_q)
         ST_ACC: begin
            if (accept) begin
               if (in_last) begin
                  out_pos_d   = nxt_p;
                  out_neg_d   = nxt_n;
                  out_beats_d = nxt_b;
                  out_sat_d   = nxt_sat;
                  out_ge_d    = decision;
                  out_valid_d = 1'b1;
                  acc_p_d     = '0;
                  acc_n_d     = '0;
                  beats_d     = '0;
                  sat_d       = 1'b0;
                  state_d     = ST_DONE;
               end else begin
                  acc_p_d = nxt_p;
                  acc_n_d = nxt_n;
                  beats_d = nxt_b;
                  sat_d   = nxt_sat;
               end
            end
         end
         ST_DONE: begin
            // Result data stays in place after the handshake; only valid drops.
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_ACC;
            end
         end
         default: state_d = ST_ACC;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_ACC;
         acc_p_q     <= '0;
         acc_n_q     <= '0;
         beats_q     <= '0;
         sat_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_ge_q    <= 1'b0;
         out_pos_q   <= '0;
         out_neg_q   <= '0;
         out_beats_q <= '0;
         out_sat_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_p_q     <= acc_p_d;
         acc_n_q     <= acc_n_d;
         beats_q     <= beats_d;
         sat_q       <= sat_d;
         out_valid_q <= out_valid_d;
         out_ge_q    <= out_ge_d;
         out_pos_q   <= out_pos_d;
         out_neg_q   <= out_neg_d;
         out_beats_q <= out_beats_d;
         out_sat_q   <= out_sat_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_ge      = out_ge_q;
   assign out_pos_cnt = out_pos_q;
   assign out_neg_cnt = out_neg_q;
   assign out_beats   = out_beats_q;
   assign out_sat     = out_sat_q;

endmodule

// File: doc/pcc_stream_acc.md
Name: pcc_stream_acc

Overview:
Streaming, parametrised successor to the single-shot popcount comparator.
- Takes a frame of one or more beats. Each beat carries a POS_W-bit positive vector and a NEG_W-bit negative vector.
- Keeps saturating running popcounts of both vectors across the frame.
- At frame end, outputs the decision "positive count >= negative count" together with both counts and the beat count.
- Sits between the feature-bit producer and the classifier output stage; valid/ready on both sides.

Parameters:
POS_W, 2, width of positive input vector per beat (>=1)
NEG_W, 6, width of negative input vector per beat (>=1)
CNT_W, 8, width of accumulators and count outputs (must satisfy 2^CNT_W-1 >= max(POS_W,NEG_W))

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  beat offered
in_ready  output  1  block can accept a beat
in_pos  input  POS_W  positive bits of this beat
in_neg  input  NEG_W  negative bits of this beat
in_last  input  1  beat is final beat of frame
out_valid  output  1  frame result available
out_ready  input  1  consumer takes result
out_ge  output  1  1 when final pos count >= final neg count (unsigned)
out_pos_cnt  output  CNT_W  final saturated positive count
out_neg_cnt  output  CNT_W  final saturated negative count
out_beats  output  CNT_W  beats in frame, saturated
out_sat  output  1  any accumulator or beat counter saturated during frame
thresh  input  CNT_W+1  signed threshold; port exists only with PCC_THRESH_EN

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. While rst_n=0, all registers clear immediately, independent of clk.
- Reset values: state=ACC, accumulators=0, beat counter=0. out_valid=0, out_ge=0, out_pos_cnt=0, out_neg_cnt=0, out_beats=0, out_sat=0.
- in_ready is combinational: 1 iff state==ACC. No dependence on out_ready.
- Beat acceptance: a beat is accepted on a rising edge with in_valid && in_ready.
- State ACC, accepted beat:
  - pc_p = popcount(in_pos), pc_n = popcount(in_neg).
  - nxt_p = sat(acc_p + pc_p), nxt_n = sat(acc_n + pc_n), nxt_b = sat(beats + 1).
  - sat(x) = min(x, 2^CNT_W-1). Compute sums in CNT_W+1 bits before clamping.
  - Sticky sat flag is set if any clamp occurred.
- Accepted beat with in_last=0: acc_p/acc_n/beats/sat take the nxt values; stay in ACC.
- Accepted beat with in_last=1:
  - Load out_pos_cnt=nxt_p, out_neg_cnt=nxt_n, out_beats=nxt_b, out_sat=sat flag including this beat's clamps.
  - out_ge = (nxt_p >= nxt_n).
  - Clear accumulators, beat counter and sat flag to 0.
  - Go to DONE.
- Latency: out_valid=1 in the cycle immediately after the edge that accepts the last beat. A 1-beat frame gives a result 1 cycle after acceptance.
- State DONE:
  - out_valid=1, in_ready=0.
  - Outputs hold stable until handshake.
  - On an edge with out_ready=1: out_valid→0, state→ACC. Output data registers keep their last values.
- State ACC with no accepted beat: everything holds. in_valid with in_ready=0 is ignored, with no side effect.
- Empty frame (in_last never seen): accumulation continues; counters saturate and stick at 2^CNT_W-1; out_sat reports it at frame end.
- Reset mid-frame or in DONE: the partial frame and any pending result are discarded; state returns to ACC.
- out_ready while out_valid=0: ignored.
- Tie: equal counts give out_ge=1. Both saturated gives out_ge=1.

Optional Feature:
Macro: PCC_THRESH_EN
- Defined:
  - Port thresh exists.
  - thresh is sampled on the edge accepting the last beat.
  - Decision becomes out_ge = (nxt_p - nxt_n) >= thresh, evaluated signed in CNT_W+2 bits.
  - thresh = 0 reproduces the default compare.
- Undefined: port absent; out_ge = (nxt_p >= nxt_n).

Test Plan:
- Reset, then single beat with POS_W=2, NEG_W=6, in_pos=2'b11, in_neg=6'b000111, in_last=1 -> next cycle: out_valid=1, out_pos_cnt=2, out_neg_cnt=3, out_beats=1, out_ge=0, out_sat=0.
- 3-beat frame: pos 2'b01,2'b11,2'b10; neg 6'b000001,6'b0,6'b000011 -> pos=4, neg=3, beats=3, out_ge=1. in_ready=0 while out_valid=1.
- Backpressure: out_ready=0 for 5 cycles after result -> outputs stable, in_ready=0, offered beats not consumed. out_ready=1 -> out_valid=0 next cycle, in_ready=1.
- Saturation with CNT_W=3: 2 beats of in_neg=6'b111111, in_pos=0 -> out_neg_cnt=7, out_sat=1, out_ge=0. Next frame starts from 0 with out_sat=0.
- Async reset asserted mid-frame (between clk edges) after 2 beats -> outputs and accumulators clear immediately. A following 1-beat frame with pos=1, neg=0 gives pos=1, beats=1.
- PCC_THRESH_EN defined: final pos=4, neg=3. thresh=+1 -> out_ge=1; thresh=+2 -> out_ge=0; thresh=-3 with pos=0, neg=3 -> out_ge=1.
